// File: rtl/ram_loader.sv
// Byte-stream front-end that assembles high-byte-first 16-bit words and writes them to a 64-word RAM.
// Optional running checksum of written words is enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_address,
  input  logic [ADDR_WIDTH:0]       word_count,
  input  logic [WORD_WIDTH/2-1:0]   byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  output logic [WORD_WIDTH-1:0]     ram_in,
  output logic                      ram_load,
  output logic [ADDR_WIDTH-1:0]     ram_address,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_WIDTH-1:0]     checksum
);

  localparam int unsigned BYTE_WIDTH = WORD_WIDTH / 2;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [CNT_WIDTH-1:0]   remain_q;
  logic [BYTE_WIDTH-1:0]  high_q;
  logic [WORD_WIDTH-1:0]  ram_in_q;
  logic                   byte_ready_q;
  logic                   ram_load_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CNT_WIDTH-1:0]   count_clamped_c;
  logic                   handshake_c;

  // A session can never write more words than the RAM holds.
  assign count_clamped_c = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign handshake_c     = byte_valid && byte_ready_q;

  // Session FSM; the output flags are registered alongside the state they belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      high_q       <= '0;
      ram_in_q     <= '0;
      byte_ready_q <= 1'b0;
      ram_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q   <= base_address;
            remain_q <= count_clamped_c;
            if (count_clamped_c == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_HIGH;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (handshake_c) begin
            high_q  <= byte_in;
            state_q <= S_LOW;
          end
        end
        S_LOW: begin
          if (handshake_c) begin
            ram_in_q     <= {high_q, byte_in};
            state_q      <= S_WRITE;
            byte_ready_q <= 1'b0;
            ram_load_q   <= 1'b1;
          end
        end
        S_WRITE: begin
          ram_load_q <= 1'b0;
          addr_q     <= ADDR_WIDTH'(addr_q + 1'b1);
          remain_q   <= CNT_WIDTH'(remain_q - 1'b1);
          if (remain_q == CNT_WIDTH'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q      <= S_HIGH;
            byte_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          ram_load_q   <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready  = byte_ready_q;
  assign ram_in      = ram_in_q;
  assign ram_load    = ram_load_q;
  assign ram_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_q;

  // Sum of words written in the current session; holds after completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      checksum_q <= '0;
    end else if (state_q == S_WRITE) begin
      checksum_q <= WORD_WIDTH'(checksum_q + ram_in_q);
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Randomized scoreboard bench for ram_loader: a session model predicts every RAM write and completion.
module tb_ram_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  base_address;
  logic [6:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [5:0]  ram_address;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx[$];
  int          exp_addr[$];
  int          exp_data[$];
  int          exp_done_addr[$];
  int          exp_done_sum[$];

  ram_loader #(.WORD_WIDTH(16), .ADDR_WIDTH(6)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .base_address (base_address),
    .word_count   (word_count),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .ram_in       (ram_in),
    .ram_load     (ram_load),
    .ram_address  (ram_address),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write and every completion is matched against the scoreboard.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (ram_load === 1'b1) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", ram_address, ram_in);
        end else begin
          check("write_addr", 32'(ram_address), 32'(exp_addr.pop_front()));
          check("write_data", 32'(ram_in), 32'(exp_data.pop_front()));
          check("ready_in_write", 32'(byte_ready), 32'd0);
          check("done_with_load", 32'(done), 32'd0);
        end
      end
      if (done === 1'b1) begin
        if (exp_done_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          check("final_addr", 32'(ram_address), 32'(exp_done_addr.pop_front()));
          check("final_checksum", 32'(checksum), 32'(exp_done_sum.pop_front()));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {byte_ready, ram_load, busy, done, 4'd0, ram_in}, 32'd0);
    check({name, "_addr_sum"}, {10'd0, ram_address, checksum}, 32'd0);
  endtask

  // Present one byte after an optional idle gap and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit glitch);
    int t = 0;
    if (glitch) begin
      start        = 1'b1;
      base_address = 6'($urandom);
      word_count   = 7'($urandom);
    end
    byte_valid = 1'b0;
    repeat (gap) @(negedge clock);
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 64) begin
      @(negedge clock);
      t++;
    end
    if (t >= 64) check("byte_accept_timeout", 32'(byte_ready), 32'd1);
    @(negedge clock);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  // gap_mode < 0: random 0..2 idle cycles before each byte; otherwise a fixed gap.
  task automatic run_session(input int base, input int cnt, input int gap_mode, input bit glitch);
    int eff;
    int sum;
    logic [15:0] w;
    logic [15:0] last_w;
    eff = (cnt > 64) ? 64 : cnt;
    while (tx.size() < 2 * eff) tx.push_back(8'($urandom));
    sum    = 0;
    last_w = 16'd0;
    for (int i = 0; i < eff; i++) begin
      w = {tx[2*i], tx[2*i+1]};
      exp_addr.push_back((base + i) % 64);
      exp_data.push_back(int'(w));
      sum    = (sum + int'(w)) % 65536;
      last_w = w;
    end
`ifndef RAM_LOADER_CHECKSUM_EN
    sum = 0;
`endif
    exp_done_addr.push_back((base + eff) % 64);
    exp_done_sum.push_back(sum);

    start        = 1'b1;
    base_address = 6'(base);
    word_count   = 7'(cnt);
    @(negedge clock);
    start = 1'b0;
    if (eff == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_no_load", 32'(ram_load), 32'd0);
    end else begin
      check("ready_after_start", 32'(byte_ready), 32'd1);
      for (int i = 0; i < eff; i++) begin
        send_byte(tx[2*i], (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode, 1'b0);
        check("no_load_after_high", 32'(ram_load), 32'd0);
        send_byte(tx[2*i+1], (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode, glitch && i == 0);
        check("load_latency", 32'(ram_load), 32'd1);
      end
      @(negedge clock);
      check("done_latency", 32'(done), 32'd1);
    end
    @(negedge clock);
    check("idle_flags", {busy, done, byte_ready, ram_load}, 32'd0);
    check("checksum_hold", 32'(checksum), 32'(sum));
    if (eff > 0) check("ram_in_hold", 32'(ram_in), 32'(last_w));
    tx.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    base_address = '0;
    word_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;

    // Reset with random inputs, including start, must keep every output at zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      start        = 1'($urandom);
      base_address = 6'($urandom);
      word_count   = 7'($urandom);
      byte_in      = 8'($urandom);
      byte_valid   = 1'($urandom);
      #1 check_all_zero("reset_outputs");
    end
    @(negedge clock);
    start      = 1'b0;
    byte_valid = 1'b0;
    reset_n    = 1'b1;
    @(negedge clock);
    check_all_zero("post_reset_idle");

    // Basic load, then the same words under fixed two-cycle backpressure.
    tx = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_session(0, 2, 0, 1'b0);
    tx = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_session(0, 2, 2, 1'b0);

    // Address wrap, zero count, clamp, and start pulsed while busy.
    run_session(62, 4, 0, 1'b0);
    run_session(17, 0, 0, 1'b0);
    run_session(5, 100, 0, 1'b0);
    run_session(40, 3, -1, 1'b1);

    // Reset after a lone high byte: the partial word must vanish.
    @(negedge clock);
    start        = 1'b1;
    base_address = 6'd10;
    word_count   = 7'd1;
    @(negedge clock);
    start      = 1'b0;
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    @(negedge clock);
    byte_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_session_reset");
    @(negedge clock);
    check("reset_no_load", 32'(ram_load), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    tx = '{8'h01, 8'h02};
    run_session(10, 1, 0, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 20; s++) begin
      int c;
      c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      run_session(int'($urandom_range(0, 63)), c, -1, 1'($urandom));
    end

    check("scoreboard_writes_left", 32'(exp_addr.size()), 32'd0);
    check("scoreboard_done_left", 32'(exp_done_addr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
